mem_ready_responder: RTL and testbench

- Memory-side responder for the multicycle core's control FSM. It accepts one read or write request at a time, holds it for a configurable latency, then returns a one-cycle response.
- Handshake: req_ready, resp_valid and resp_err.
- The control FSM holds its memory-access state until resp_valid, which lets instruction fetch and MEM states stall on a slow memory.

---
 rtl/mem_ready_responder.sv | 103 ++++++++++
 tb/tb_mem_ready_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_ready_responder.sv
// rtl/mem_ready_responder.sv - single-request memory responder with fixed response latency
module mem_ready_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  accept;
  logic                  commit;
  logic                  direct;
  logic                  eff_write;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_din;
  logic [IDX_W-1:0]      eff_idx;
  logic                  misaligned;
  logic                  unused_addr_bits;

  assign accept = (state_q == IDLE) && (mem_read ^ mem_write);
  assign commit = ((state_q == BUSY) && (cnt_q == '0)) || (accept && (LATENCY == 1));

  // With LATENCY==1 the commit happens on the accepting edge, so use live inputs.
  assign direct     = (state_q == IDLE);
  assign eff_write  = direct ? mem_write : write_q;
  assign eff_addr   = direct ? addr : addr_q;
  assign eff_din    = direct ? din : din_q;
  assign eff_idx    = eff_addr[IDX_W+1:2];
  assign misaligned = (eff_addr[1:0] != 2'b00);
  assign unused_addr_bits = ^eff_addr[ADDR_WIDTH-1:IDX_W+2];

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_err   = err_q;
  assign dout       = dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= mem_write;
            addr_q  <= addr;
            din_q   <= din;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? DONE : BUSY;
          end else if (mem_read && mem_write) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        err_q <= misaligned;
        if (!eff_write) dout_q <= misaligned ? '0 : mem_q[eff_idx];
      end
    end
  end

  // Array is deliberately outside the reset domain; a reset edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && eff_write && !misaligned) mem_q[eff_idx] <= eff_din;
  end

endmodule

// File: tb/tb_mem_ready_responder.sv
// tb/tb_mem_ready_responder.sv - directed bench for mem_ready_responder (LATENCY 4 and 1)
module tb_mem_ready_responder;

  logic        clk;
  logic        rst4, rd4, wr4, rdy4, rv4, re4;
  logic [31:0] addr4, din4, dout4;
  logic        rst1, rd1, wr1, rdy1, rv1, re1;
  logic [31:0] addr1, din1, dout1;
  int          checks;
  int          errors;

  mem_ready_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(16384), .LATENCY(4)) u4 (
    .clk(clk), .reset(rst4), .mem_read(rd4), .mem_write(wr4), .addr(addr4), .din(din4),
    .req_ready(rdy4), .resp_valid(rv4), .resp_err(re4), .dout(dout4)
  );

  mem_ready_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(16384), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst1), .mem_read(rd1), .mem_write(wr1), .addr(addr1), .din(din1),
    .req_ready(rdy1), .resp_valid(rv1), .resp_err(re1), .dout(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=4 instance and wait (bounded) for its response.
  task automatic req4(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_dout, input string tag);
    int n;
    n = 0;
    rd4 = rd; wr4 = wr; addr4 = a; din4 = d;
    @(negedge clk);
    rd4 = 1'b0; wr4 = 1'b0;
    while (!rv4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 32'd4);
    chk({tag, "_err"}, {31'd0, re4}, {31'd0, exp_err});
    chk({tag, "_dout"}, dout4, exp_dout);
    @(negedge clk);
  endtask

  initial begin
    int hits;
    checks = 0; errors = 0;
    rst4 = 1'b1; rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; din4 = '0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0; rst1 = 1'b0;
    chk("rst_ready", {31'd0, rdy4}, 32'd1);
    chk("rst_valid", {31'd0, rv4}, 32'd0);
    chk("rst_err", {31'd0, re4}, 32'd0);
    chk("rst_dout", dout4, 32'd0);

    // Write 0x10 with cycle-by-cycle handshake checks
    wr4 = 1'b1; addr4 = 32'h10; din4 = 32'hDEADBEEF;
    @(negedge clk);
    wr4 = 1'b0;
    chk("w_ready_e0", {31'd0, rdy4}, 32'd0);
    chk("w_valid_e0", {31'd0, rv4}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("w_valid_busy", {31'd0, rv4}, 32'd0);
    end
    @(negedge clk);
    chk("w_valid_e4", {31'd0, rv4}, 32'd1);
    chk("w_err_e4", {31'd0, re4}, 32'd0);
    chk("w_ready_e4", {31'd0, rdy4}, 32'd0);
    @(negedge clk);
    chk("w_valid_e5", {31'd0, rv4}, 32'd0);
    chk("w_ready_e5", {31'd0, rdy4}, 32'd1);

    req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd10");
    repeat (10) @(negedge clk);
    chk("dout_hold", dout4, 32'hDEADBEEF);
    chk("idle_ready", {31'd0, rdy4}, 32'd1);

    // Misaligned write leaves memory and dout alone; misaligned read zeroes dout
    req4(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF, "wmis");
    req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd10_after_mis");
    req4(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, "rmis");

    // Read and write together in IDLE: protocol error pulse only
    rd4 = 1'b1; wr4 = 1'b1; addr4 = 32'h10; din4 = 32'h5;
    @(negedge clk);
    rd4 = 1'b0; wr4 = 1'b0;
    chk("both_err", {31'd0, re4}, 32'd1);
    chk("both_valid", {31'd0, rv4}, 32'd0);
    chk("both_ready", {31'd0, rdy4}, 32'd1);
    @(negedge clk);
    chk("both_err_clr", {31'd0, re4}, 32'd0);
    req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd10_after_both");

    // Reset while BUSY drops the pending write
    req4(1'b0, 1'b1, 32'h40, 32'h11112222, 1'b0, 32'hDEADBEEF, "w40_old");
    wr4 = 1'b1; addr4 = 32'h40; din4 = 32'hAAAA5555;
    @(negedge clk);
    wr4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("rstbusy_ready", {31'd0, rdy4}, 32'd1);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (rv4) hits++;
      @(negedge clk);
    end
    chk("rstbusy_novalid", hits, 32'd0);
    req4(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h11112222, "rd40");

    // Address wrap modulo the array size
    req4(1'b0, 1'b1, 32'h0001_0004, 32'h77, 1'b0, 32'h11112222, "wwrap");
    req4(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h77, "rdwrap");

    // LATENCY=1: write then held read, accepted two edges apart
    wr1 = 1'b1; addr1 = 32'h20; din1 = 32'h1234;
    @(negedge clk);
    chk("l1_w_valid", {31'd0, rv1}, 32'd1);
    chk("l1_w_err", {31'd0, re1}, 32'd0);
    chk("l1_w_ready", {31'd0, rdy1}, 32'd0);
    wr1 = 1'b0; rd1 = 1'b1;
    @(negedge clk);
    chk("l1_gap_valid", {31'd0, rv1}, 32'd0);
    chk("l1_gap_ready", {31'd0, rdy1}, 32'd1);
    @(negedge clk);
    rd1 = 1'b0;
    chk("l1_r_valid", {31'd0, rv1}, 32'd1);
    chk("l1_r_dout", dout1, 32'h1234);
    @(negedge clk);
    chk("l1_idle_valid", {31'd0, rv1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
